// File: rtl/fetch_sequencer.sv
// fetch_sequencer: keeps the fetch PC, issues word-aligned imem reads and
// buffers returned words (with their PC and jump tag) in a small FIFO for the
// IR assembly stage. A redirect flushes buffered words and any in-flight
// response, then fetch resumes at the target.
// Optional build macro: FETCH_PERF_EN adds perf_fetch / perf_flush counters.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0060,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_read,
   output logic [31:0] imem_address,
   input  logic        imem_resp,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        fw_ready,
   output logic        fw_valid,
   output logic [31:0] fw_data,
   output logic [31:0] fw_pc,
   output logic        fw_j
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch,
   output logic [15:0] perf_flush
`endif
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [31:0]   fpc_q, fpc_d;
   logic          jpend_q, jpend_d;
   logic [31:0]   drain_addr_q, drain_addr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];
   logic          j_mem    [DEPTH];
   logic [DEPTH-1:0] we;

   logic [31:0]   fetch_addr;
   logic          push;
   logic          pop;
   logic          room_next;

   // Datapath controls: what gets pushed/popped and the resulting occupancy
   always_comb begin
      fetch_addr = {fpc_q[31:2], 2'b00};
      push       = (state_q == REQ) && imem_resp && !redirect;
      pop        = (count_q != '0) && fw_ready && !redirect;
      if (redirect) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         count_d  = count_q + CW'(push) - CW'(pop);
         wr_ptr_d = wr_ptr_q + PW'(push);
         rd_ptr_d = rd_ptr_q + PW'(pop);
      end
      room_next = (count_d < CW'(DEPTH));
   end

   // Fetch PC and jump-pending tag: redirect wins over an advancing push
   always_comb begin
      fpc_d   = fpc_q;
      jpend_d = jpend_q;
      if (redirect) begin
         fpc_d   = redirect_pc;
         jpend_d = 1'b1;
      end else if (push) begin
         fpc_d   = fetch_addr + 32'd4;
         jpend_d = 1'b0;
      end
   end

   // Next-state logic and imem port outputs
   always_comb begin
      state_d      = state_q;
      drain_addr_d = drain_addr_q;
      imem_read    = 1'b0;
      imem_address = fetch_addr;
      case (state_q)
         IDLE: begin
            if (redirect || room_next) state_d = REQ;
         end
         REQ: begin
            imem_read = 1'b1;
            if (redirect) begin
               if (!imem_resp) begin
                  // in-flight read cannot be aborted; remember its address
                  state_d      = DRAIN;
                  drain_addr_d = fetch_addr;
               end
            end else if (imem_resp) begin
               state_d = room_next ? REQ : IDLE;
            end
         end
         DRAIN: begin
            imem_read    = 1'b1;
            imem_address = drain_addr_q;
            if (imem_resp) state_d = REQ;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state register with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         fpc_q        <= RESET_PC;
         jpend_q      <= 1'b1;
         drain_addr_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         fpc_q        <= fpc_d;
         jpend_q      <= jpend_d;
         drain_addr_q <= drain_addr_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // Per-entry write enables
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign we[gi] = push && (wr_ptr_q == PW'(gi));
   end

   // FIFO storage; contents need no reset because occupancy is tracked separately
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (we[i]) begin
            data_mem[i] <= imem_rdata;
            pc_mem[i]   <= fpc_q;
            j_mem[i]    <= jpend_q;
         end
      end
   end

   // Head of FIFO presented combinationally so a word is visible the cycle after its push
   always_comb begin
      fw_valid = (count_q != '0);
      fw_data  = data_mem[rd_ptr_q];
      fw_pc    = pc_mem[rd_ptr_q];
      fw_j     = j_mem[rd_ptr_q];
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_q;
   logic [15:0] perf_flush_q;
   logic        discard;
   logic [15:0] flushed;

   // Discarded responses: any accepted-cycle response that did not push
   always_comb begin
      discard = imem_resp && imem_read && !push;
      flushed = redirect ? 16'(count_q) : 16'd0;
   end

   // Wrapping performance counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_q <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_fetch_q <= perf_fetch_q + 32'(push);
         perf_flush_q <= perf_flush_q + 16'(discard) + flushed;
      end
   end

   assign perf_fetch = perf_fetch_q;
   assign perf_flush = perf_flush_q;
`endif

endmodule
